// File: rtl/rv_mc_pkg.sv
// rtl/rv_mc_pkg.sv - shared constants and state encoding for the multi-cycle control unit
package rv_mc_pkg;

    // Controller states; FETCH is the reset state.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    // Supported major opcodes (IR[6:0]).
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation class.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU A operand select.
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_OLD_PC = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    // Register writeback select.
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // Dispatch target out of DECODE; anything unrecognised traps.
    function automatic state_t decode_target(input logic [6:0] op);
        state_t target;
        case (op)
            OP_R:               target = EXEC_R;
            OP_I:               target = EXEC_I;
            OP_LOAD, OP_STORE:  target = MEM_ADDR;
            OP_BRANCH:          target = BRANCH;
            OP_JAL:             target = JAL;
            default:            target = TRAP;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore control FSM sequencing the shared multi-cycle RISC-V datapath
module multicycle_control_unit
    import rv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       retire,
    output logic       illegal
);

    state_t state;
    state_t state_next;

    // State register: reset always lands in FETCH, whatever was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: memory states wait on mem_ready, TRAP is absorbing.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE:   state_next = decode_target(opcode);
            EXEC_R:   state_next = WB_ALU;
            EXEC_I:   state_next = WB_ALU;
            MEM_ADDR: state_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
            MEM_RD:   state_next = mem_ready ? WB_MEM : MEM_RD;
            MEM_WR:   state_next = mem_ready ? FETCH : MEM_WR;
            WB_ALU:   state_next = FETCH;
            WB_MEM:   state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JAL:      state_next = FETCH;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    // Output decode: all zero under reset so no strobe leaks in the reset cycle.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        aluop      = ALUOP_ADD;
        reg_write  = 1'b0;
        mem_to_reg = WB_ALUOUT;
        retire     = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    // PC <= PC + 4 and IR <= mem only when the read completes.
                    mem_read  = 1'b1;
                    i_or_d    = 1'b0;
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_FOUR;
                    aluop     = ALUOP_ADD;
                    pc_src    = PCSRC_ALU;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    // Speculatively compute old PC + imm into ALUOut for BEQ/JAL.
                    alu_src_a = SRCA_OLD_PC;
                    alu_src_b = SRCB_IMM;
                    aluop     = ALUOP_ADD;
                end
                EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    aluop     = ALUOP_FUNCT;
                end
                EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    aluop     = ALUOP_FUNCT;
                end
                MEM_ADDR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    aluop     = ALUOP_ADD;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WR: begin
                    // Store retires in the cycle the write is accepted.
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                end
                WB_ALU: begin
                    reg_write  = 1'b1;
                    mem_to_reg = WB_ALUOUT;
                    retire     = 1'b1;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = WB_MDR;
                    retire     = 1'b1;
                end
                BRANCH: begin
                    // rs1 - rs2 sets zero; take the target held in ALUOut on equality.
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    aluop     = ALUOP_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = zero;
                    retire    = 1'b1;
                end
                JAL: begin
                    // PC already holds PC + 4, which is the link value.
                    reg_write  = 1'b1;
                    mem_to_reg = WB_PC;
                    pc_write   = 1'b1;
                    pc_src     = PCSRC_ALUOUT;
                    retire     = 1'b1;
                end
                TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_MEM_ADDR = 4,
                   S_MEM_RD = 5, S_MEM_WR = 6, S_WB_ALU = 7, S_WB_MEM = 8, S_BRANCH = 9,
                   S_JAL = 10, S_TRAP = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b, aluop, mem_to_reg;
    logic       reg_write, retire, illegal;

    typedef struct {
        string       tag;
        logic [17:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .aluop(aluop), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [17:0] got = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                       alu_src_b, aluop, reg_write, mem_to_reg, retire, illegal};

    function automatic logic [17:0] pack(input logic mrd, input logic mwr, input logic iod,
                                         input logic irw, input logic pcw, input logic [1:0] pcs,
                                         input logic [1:0] sa, input logic [1:0] sbb,
                                         input logic [1:0] aop, input logic rw,
                                         input logic [1:0] m2r, input logic ret, input logic ill);
        return {mrd, mwr, iod, irw, pcw, pcs, sa, sbb, aop, rw, m2r, ret, ill};
    endfunction

    // Expected outputs for a given state, written straight from the state table.
    function automatic logic [17:0] expect_for(input int st, input logic mr, input logic z);
        case (st)
            S_FETCH:    return pack(1, 0, 0, mr, mr, 2'b00, 2'b00, 2'b01, 2'b00, 0, 2'b00, 0, 0);
            S_DECODE:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0, 2'b00, 0, 0);
            S_EXEC_R:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b10, 0, 2'b00, 0, 0);
            S_EXEC_I:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 0, 2'b00, 0, 0);
            S_MEM_ADDR: return pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'b00, 0, 0);
            S_MEM_RD:   return pack(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);
            S_MEM_WR:   return pack(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, mr, 0);
            S_WB_ALU:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0);
            S_WB_MEM:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b01, 1, 0);
            S_BRANCH:   return pack(0, 0, 0, 0, z, 2'b01, 2'b01, 2'b00, 2'b01, 0, 2'b00, 1, 0);
            S_JAL:      return pack(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 2'b10, 1, 0);
            S_TRAP:     return pack(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1);
            default:    return 18'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show in that cycle.
    task automatic cyc(input logic r, input logic [6:0] op, input logic z, input logic mr,
                       input int st, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = r;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        e.tag = tag;
        e.exp = r ? 18'h0 : expect_for(st, mr, z);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, got, e.exp);
        end
    end

    initial begin
        // Reset held two cycles, outputs must be zero even in FETCH-like inputs.
        cyc(1, 7'b0110011, 0, 1, S_FETCH, "rst0");
        cyc(1, 7'b0110011, 0, 1, S_FETCH, "rst1");
        // R-type
        cyc(0, 7'b0110011, 0, 1, S_FETCH,  "r_fetch");
        cyc(0, 7'b0110011, 0, 1, S_DECODE, "r_decode");
        cyc(0, 7'b0110011, 0, 1, S_EXEC_R, "r_exec");
        cyc(0, 7'b0110011, 0, 1, S_WB_ALU, "r_wb");
        // Load with two wait cycles in MEM_RD
        cyc(0, 7'b0000011, 0, 1, S_FETCH,    "ld_fetch");
        cyc(0, 7'b0000011, 0, 1, S_DECODE,   "ld_decode");
        cyc(0, 7'b0000011, 0, 1, S_MEM_ADDR, "ld_addr");
        cyc(0, 7'b0000011, 0, 0, S_MEM_RD,   "ld_wait0");
        cyc(0, 7'b0000011, 0, 0, S_MEM_RD,   "ld_wait1");
        cyc(0, 7'b0000011, 0, 1, S_MEM_RD,   "ld_done");
        cyc(0, 7'b0000011, 0, 1, S_WB_MEM,   "ld_wb");
        // BEQ taken, then not taken (mem_ready low outside memory states is ignored)
        cyc(0, 7'b1100011, 1, 1, S_FETCH,  "beq1_fetch");
        cyc(0, 7'b1100011, 1, 0, S_DECODE, "beq1_decode");
        cyc(0, 7'b1100011, 1, 0, S_BRANCH, "beq1_branch");
        cyc(0, 7'b1100011, 0, 1, S_FETCH,  "beq0_fetch");
        cyc(0, 7'b1100011, 0, 1, S_DECODE, "beq0_decode");
        cyc(0, 7'b1100011, 0, 1, S_BRANCH, "beq0_branch");
        // JAL
        cyc(0, 7'b1101111, 0, 1, S_FETCH,  "jal_fetch");
        cyc(0, 7'b1101111, 0, 1, S_DECODE, "jal_decode");
        cyc(0, 7'b1101111, 0, 1, S_JAL,    "jal_exec");
        // I-type with a stalled fetch
        cyc(0, 7'b0010011, 0, 0, S_FETCH,  "i_fetch_wait");
        cyc(0, 7'b0010011, 0, 1, S_FETCH,  "i_fetch");
        cyc(0, 7'b0010011, 0, 1, S_DECODE, "i_decode");
        cyc(0, 7'b0010011, 0, 0, S_EXEC_I, "i_exec");
        cyc(0, 7'b0010011, 0, 0, S_WB_ALU, "i_wb");
        // Store, one wait cycle
        cyc(0, 7'b0100011, 0, 1, S_FETCH,    "st_fetch");
        cyc(0, 7'b0100011, 0, 1, S_DECODE,   "st_decode");
        cyc(0, 7'b0100011, 0, 1, S_MEM_ADDR, "st_addr");
        cyc(0, 7'b0100011, 0, 0, S_MEM_WR,   "st_wait");
        cyc(0, 7'b0100011, 0, 1, S_MEM_WR,   "st_done");
        // Store interrupted by reset while waiting
        cyc(0, 7'b0100011, 0, 1, S_FETCH,    "str_fetch");
        cyc(0, 7'b0100011, 0, 1, S_DECODE,   "str_decode");
        cyc(0, 7'b0100011, 0, 1, S_MEM_ADDR, "str_addr");
        cyc(0, 7'b0100011, 0, 0, S_MEM_WR,   "str_wait");
        cyc(1, 7'b0100011, 0, 0, S_MEM_WR,   "str_reset");
        cyc(0, 7'b0100011, 0, 1, S_FETCH,    "str_refetch");
        // Illegal opcode traps until reset
        cyc(0, 7'b0000000, 0, 1, S_DECODE, "trap_decode");
        for (int i = 0; i < 10; i++) begin
            cyc(0, 7'b0000000, logic'(i[0]), logic'(i[1]), S_TRAP, $sformatf("trap_hold%0d", i));
        end
        cyc(1, 7'b0000000, 0, 1, S_TRAP,  "trap_reset");
        cyc(0, 7'b0110011, 0, 1, S_FETCH, "trap_refetch");
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
